// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the sequencer channel bank.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned ChDefault    = 4;
  localparam int unsigned CwDefault    = 4;
  localparam int unsigned LimitDefault = 10;

endpackage

// File: rtl/seq_ctrl_chan.sv
// One sequencer channel: IDLE/REQ/RUN/DONE FSM plus its run counter.
// With SEQ_CTRL_SCAN_EN defined, {state, count} also forms a scan segment.
module seq_ctrl_chan
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CW    = CwDefault,
  parameter int unsigned LIMIT = LimitDefault
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          grant_i,
`ifdef SEQ_CTRL_SCAN_EN
  input  logic          se_i,
  input  logic          si_i,
  output logic          so_o,
`endif
  output logic [1:0]    state_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] LastCount = CW'(LIMIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

`ifdef SEQ_CTRL_SCAN_EN
  logic [CW+1:0] shifted;
  // State bits lead the segment, so they leave first on the way to SO.
  assign shifted = {state_q[0], count_q, si_i};
  assign so_o    = state_q[1];
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: if (start_i && !abort_i) state_d = StReq;
      StReq: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (grant_i) begin
          state_d = StRun;
          count_d = '0;
        end
      end
      StRun: begin
        if (abort_i) state_d = StIdle;
        else if (count_q == LastCount) state_d = StDone;
        else count_d = count_q + CW'(1);
      end
      default: state_d = StIdle;
    endcase
`ifdef SEQ_CTRL_SCAN_EN
    if (se_i) begin
      state_d = state_e'(shifted[CW+1:CW]);
      count_d = shifted[CW-1:0];
    end
`endif
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/seq_ctrl_bank.sv
// Bank of CH sequencer channels sharing one RUN slot via a round-robin arbiter.
// Optional scan chain (SE/SI/SO) enabled by defining SEQ_CTRL_SCAN_EN.
module seq_ctrl_bank
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CH    = ChDefault,
  parameter int unsigned CW    = CwDefault,
  parameter int unsigned LIMIT = LimitDefault
) (
  input  logic             CK,
  input  logic             RST,
`ifdef SEQ_CTRL_SCAN_EN
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
`endif
  input  logic [CH-1:0]    start,
  input  logic [CH-1:0]    abort,
  input  logic [CH-1:0]    oe,
  output logic [CH-1:0]    out_active,
  output logic [CH-1:0]    out_done,
  output logic [CH-1:0]    grant,
  output logic             busy,
  output logic [CH*CW-1:0] count
);

  localparam int unsigned PW = (CH > 1) ? $clog2(CH) : 1;

  logic [PW-1:0]    ptr_q, ptr_d, idx;
  logic [CH-1:0]    is_req, is_run, is_done, grant_raw;
  logic [CH*CW-1:0] count_raw;
  logic             scan_hold, quiet, found;

`ifdef SEQ_CTRL_SCAN_EN
  logic [CH:0] chain;
  logic [PW:0] ptr_shift;
  assign chain[0]  = SI;
  assign scan_hold = SE;
  assign ptr_shift = {ptr_q, chain[CH]};
  assign SO        = ptr_q[PW-1];
`else
  assign scan_hold = 1'b0;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_chan
    logic [1:0] st;
    seq_ctrl_chan #(
      .CW   (CW),
      .LIMIT(LIMIT)
    ) u_chan (
      .CK     (CK),
      .RST    (RST),
      .start_i(start[i]),
      .abort_i(abort[i]),
      .grant_i(grant_raw[i]),
`ifdef SEQ_CTRL_SCAN_EN
      .se_i   (SE),
      .si_i   (chain[i]),
      .so_o   (chain[i+1]),
`endif
      .state_o(st),
      .count_o(count_raw[i*CW +: CW])
    );
    assign is_req[i]  = (st == StReq);
    assign is_run[i]  = (st == StRun);
    assign is_done[i] = (st == StDone);
  end

  // Outputs are forced quiet while in reset or while the scan chain shifts.
  assign quiet = RST || scan_hold;

  always_comb begin
    grant_raw = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    idx       = '0;
    if (!quiet && !(|is_run)) begin
      for (int unsigned k = 0; k < CH; k++) begin
        idx = PW'((32'(ptr_q) + k) % CH);
        if (!found && is_req[idx]) begin
          found          = 1'b1;
          grant_raw[idx] = 1'b1;
          ptr_d          = PW'((32'(idx) + 1) % CH);
        end
      end
    end
`ifdef SEQ_CTRL_SCAN_EN
    if (SE) ptr_d = ptr_shift[PW-1:0];
`endif
  end

  always_ff @(posedge CK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign grant      = grant_raw;
  assign busy       = !quiet && (|is_run);
  assign out_active = quiet ? '0 : (is_run & oe);
  assign out_done   = quiet ? '0 : (is_done & oe);
  assign count      = RST ? '0 : count_raw;

endmodule

// File: doc/seq_ctrl_bank.md
SEQ_CTRL_BANK -- requirements
Module: seq_ctrl_bank

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent channels (1..16).
REQ-002 SHALL have parameter CW, default 4, meaning per-channel run-counter width.
REQ-003 SHALL have parameter LIMIT, default 10, meaning RUN length in cycles, legal range 1..2^CW-1.
REQ-004 SHALL have port CK  input  1  sole clock, all flops rising-edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  CH  per-channel start request.
REQ-007 SHALL have port abort  input  CH  per-channel abort.
REQ-008 SHALL have port oe  input  CH  per-channel output gate.
REQ-009 SHALL have port out_active  output  CH  channel i in RUN AND oe[i].
REQ-010 SHALL have port out_done  output  CH  channel i in DONE AND oe[i].
REQ-011 SHALL have port grant  output  CH  one-hot-or-zero, channel moving REQ->RUN this cycle.
REQ-012 SHALL have port busy  output  1  some channel in RUN.
REQ-013 SHALL have port count  output  CH*CW  channel i counter at bits [i*CW +: CW].

Function
REQ-014 Each channel SHALL hold one state: IDLE, REQ, RUN or DONE.
REQ-015 IDLE: start=1 and abort=0 -> REQ next cycle; otherwise stay IDLE.
REQ-016 REQ: abort=1 -> IDLE; else grant[i]=1 -> RUN with count cleared to 0; else stay REQ.
REQ-017 RUN: abort=1 -> IDLE with count held; else count==LIMIT-1 -> DONE; else count increments by 1.
REQ-018 DONE SHALL last exactly one cycle, then -> IDLE; abort and start ignored in DONE.
REQ-019 At most one channel SHALL be in RUN at any time.
REQ-020 grant SHALL be combinational and nonzero only when no channel is in RUN and at least one channel is in REQ.
REQ-021 Arbitration SHALL be round-robin: winner is the first REQ channel at or after pointer ptr, wrapping at CH-1.
REQ-022 ptr SHALL update to (winner+1) mod CH on every grant and hold otherwise.
REQ-023 Latency SHALL be: start sampled at edge t, REQ after t, RUN after t+1 if uncontended, DONE LIMIT cycles after RUN entry.
REQ-024 The counter SHALL never wrap, since LIMIT-1 < 2^CW; count values outside RUN hold their last value.
REQ-025 An oe change SHALL affect out_active and out_done in the same cycle; oe SHALL NOT affect state.

Reset
REQ-026 RST=1 at an edge SHALL force all channels to IDLE, all counts to 0 and ptr to 0, overriding all other inputs.
REQ-027 While in reset SHALL drive out_active=0, out_done=0, grant=0, busy=0, count=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the run with no out_done pulse.

Configuration
REQ-029 With SEQ_CTRL_SCAN_EN defined, the block SHALL add ports SE (in, 1), SI (in, 1) and SO (out, 1).
REQ-030 With SE=1, all state, count and ptr flops SHALL shift one position per cycle as a single chain, channel 0 first and ptr last; no functional update occurs during the shift.
REQ-031 RST SHALL take priority over SE.
REQ-032 Without SEQ_CTRL_SCAN_EN, the ports SHALL be absent and behaviour SHALL be identical to SE=0.

Structure
REQ-033 Package seq_ctrl_pkg SHALL hold the state typedef (IDLE=2'd0, REQ=2'd1, RUN=2'd2, DONE=2'd3) and the parameter defaults.
REQ-034 Sub-module seq_ctrl_chan SHALL implement one channel FSM plus its counter.
REQ-035 The top level SHALL instantiate CH copies of seq_ctrl_chan and contain the arbiter, ptr, busy and output gating.

Verification (CH=4, CW=4, LIMIT=10)
REQ-036 Reset then start[0]=1 for one cycle, oe=4'hF -> grant[0] one cycle later, then out_active[0] high 10 cycles, count 0..9, then out_done[0] one cycle.
REQ-037 start=4'hF same cycle -> RUN order ch0, ch1, ch2, ch3, back-to-back with one DONE cycle between runs, busy never shows two channels.
REQ-038 abort[1] at count=5 in RUN -> ch1 IDLE next cycle, count holds 5, no out_done[1], waiting ch2 granted.
REQ-039 oe[2]=0 throughout a ch2 run -> out_active[2] and out_done[2] stay 0 while count still reaches 9.
REQ-040 RST during RUN at count=3 -> all outputs 0 next cycle and ptr=0; the next start[3] is granted uncontended.
REQ-041 With SEQ_CTRL_SCAN_EN: hold SE=1 for the full chain length shifting a known pattern in -> identical pattern on SO and no out_done pulse.
